// File: rtl/pool2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pool2                                                           |
// | Purpose  : 2x2 stride-2 pooling of conv2 feature maps, one read per cycle. |
// | Option   : define POOL2_AVG_EN for average pooling (default: signed max).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pool2 #(
   parameter int NUM_MAPS = 32,
   parameter int IN_DIM   = 14,
   parameter int OUT_DIM  = IN_DIM / 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] conv_maps [NUM_MAPS][IN_DIM][IN_DIM],
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic signed [31:0] pool_maps [NUM_MAPS][OUT_DIM][OUT_DIM]
);

   localparam int c_F_W = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
   localparam int c_O_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int c_R_W = c_O_W + 1;
`ifdef POOL2_AVG_EN
   localparam int c_ACC_W = 34;
`else
   localparam int c_ACC_W = 32;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [c_F_W-1:0]          r_f;
   logic [c_O_W-1:0]          r_i;
   logic [c_O_W-1:0]          r_j;
   logic [1:0]                r_k;
   logic signed [c_ACC_W-1:0] r_acc;
   logic signed [c_ACC_W-1:0] w_acc_next;
   logic [c_R_W-1:0]          w_row;
   logic [c_R_W-1:0]          w_col;
   logic signed [31:0]        w_elem;
   logic signed [31:0]        w_result;
   logic                      w_last_f;
   logic                      w_last_i;
   logic                      w_last_j;

   // Window element k sits at row 2i+k[1], column 2j+k[0].
   assign w_row    = {r_i, r_k[1]};
   assign w_col    = {r_j, r_k[0]};
   assign w_elem   = conv_maps[r_f][w_row][w_col];
   assign w_last_f = (r_f == c_F_W'(NUM_MAPS - 1));
   assign w_last_i = (r_i == c_O_W'(OUT_DIM - 1));
   assign w_last_j = (r_j == c_O_W'(OUT_DIM - 1));

   always_comb begin
      w_acc_next = r_acc;
`ifdef POOL2_AVG_EN
      if (r_k == 2'd0)
         w_acc_next = c_ACC_W'(w_elem);
      else
         w_acc_next = r_acc + c_ACC_W'(w_elem);
      // Sum of four 32-bit values fits 34 bits; >>>2 brings it back into range.
      w_result = r_acc[c_ACC_W-1:2];
`else
      if ((r_k == 2'd0) || (w_elem > r_acc))
         w_acc_next = w_elem;
      w_result = r_acc;
`endif
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_READ;
         S_READ:  if (r_k == 2'd3) w_next_state = S_WRITE;
         S_WRITE: w_next_state = (w_last_f && w_last_i && w_last_j) ? S_DONE : S_READ;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_f   <= '0;
         r_i   <= '0;
         r_j   <= '0;
         r_k   <= '0;
         r_acc <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_f  <= '0;
                  r_i  <= '0;
                  r_j  <= '0;
                  r_k  <= '0;
                  done <= 1'b0;
                  busy <= 1'b1;
               end
            end
            S_READ: begin
               r_acc <= w_acc_next;
               r_k   <= r_k + 2'd1;
            end
            S_WRITE: begin
               if (w_last_j) begin
                  r_j <= '0;
                  if (w_last_i) begin
                     r_i <= '0;
                     if (!w_last_f)
                        r_f <= r_f + c_F_W'(1);
                  end else begin
                     r_i <= r_i + c_O_W'(1);
                  end
               end else begin
                  r_j <= r_j + c_O_W'(1);
               end
            end
            S_DONE: begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int f = 0; f < NUM_MAPS; f++)
            for (int i = 0; i < OUT_DIM; i++)
               for (int j = 0; j < OUT_DIM; j++)
                  pool_maps[f][i][j] <= '0;
      end else if (r_state == S_WRITE) begin
         pool_maps[r_f][r_i][r_j] <= w_result;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pool2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pool2                                                        |
// | Purpose  : Randomized self-checking bench for pool2 (max or avg build).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pool2;

   localparam int c_NM  = 32;
   localparam int c_ID  = 14;
   localparam int c_OD  = 7;
   localparam int c_LAT = c_NM * c_OD * c_OD * 5 + 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               busy;
   logic               done;
   logic signed [31:0] conv_maps [c_NM][c_ID][c_ID];
   logic signed [31:0] pool_maps [c_NM][c_OD][c_OD];
   logic signed [31:0] exp_maps  [c_NM][c_OD][c_OD];
   logic signed [31:0] old_maps  [c_NM][c_OD][c_OD];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   pool2 #(.NUM_MAPS(c_NM), .IN_DIM(c_ID), .OUT_DIM(c_OD)) dut (
      .clk       (clk),
      .reset     (reset),
      .conv_maps (conv_maps),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pool_maps (pool_maps)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_pass;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
   endtask

   task automatic wait_done(output int lat);
      while (!done && cyc < c_LAT + 500) tick();
      lat = cyc;
   endtask

   // Reference: pick each 2x2 window directly from the input maps.
   task automatic compute_expected;
      for (int f = 0; f < c_NM; f++)
         for (int i = 0; i < c_OD; i++)
            for (int j = 0; j < c_OD; j++) begin
`ifdef POOL2_AVG_EN
               longint s = 0;
               for (int a = 0; a < 2; a++)
                  for (int b = 0; b < 2; b++)
                     s += longint'(conv_maps[f][2*i+a][2*j+b]);
               exp_maps[f][i][j] = 32'(s >>> 2);
`else
               logic signed [31:0] m;
               m = conv_maps[f][2*i][2*j];
               for (int a = 0; a < 2; a++)
                  for (int b = 0; b < 2; b++)
                     if (conv_maps[f][2*i+a][2*j+b] > m) m = conv_maps[f][2*i+a][2*j+b];
               exp_maps[f][i][j] = m;
`endif
            end
   endtask

   function automatic int map_diff;
      int d = 0;
      for (int f = 0; f < c_NM; f++)
         for (int i = 0; i < c_OD; i++)
            for (int j = 0; j < c_OD; j++)
               if (pool_maps[f][i][j] !== exp_maps[f][i][j]) d++;
      return d;
   endfunction

   task automatic fill_random;
      for (int f = 0; f < c_NM; f++)
         for (int r = 0; r < c_ID; r++)
            for (int c = 0; c < c_ID; c++)
               if ($urandom_range(3) == 0)
                  conv_maps[f][r][c] = $signed(32'($urandom_range(20))) - 32'sd10;
               else
                  conv_maps[f][r][c] = $signed($urandom);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      for (int f = 0; f < c_NM; f++)
         for (int i = 0; i < c_OD; i++)
            for (int j = 0; j < c_OD; j++) exp_maps[f][i][j] = '0;
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL reset_maps nonzero_entries=%0d want=0", map_diff()); end
      reset = 1'b1;
      start = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept busy=%b want=0", busy); end
   endtask

   task automatic test_ramp;
      int lat;
      logic signed [31:0] want;
      for (int f = 0; f < c_NM; f++)
         for (int r = 0; r < c_ID; r++)
            for (int c = 0; c < c_ID; c++) conv_maps[f][r][c] = f * 1000 + r * 14 + c;
      compute_expected();
      start_pass();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL ramp_busy got=%b want=1", busy); end
      wait_done(lat);
      n_cmp++;
      if (lat !== c_LAT) begin n_bad++; $display("FAIL ramp_latency got=%0d want=%0d", lat, c_LAT); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ramp_busy_end got=%b want=0", busy); end
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL ramp_maps bad_entries=%0d want=0", map_diff()); end
`ifdef POOL2_AVG_EN
      want = 3187;
`else
      want = 3195;
`endif
      n_cmp++;
      if (pool_maps[3][6][6] !== want)
         begin n_bad++; $display("FAIL ramp_3_6_6 got=%0d want=%0d", pool_maps[3][6][6], want); end
   endtask

   task automatic test_signed_extremes;
      int lat;
      logic signed [31:0] want;
      fill_random();
      conv_maps[0][0][0] = -5;   conv_maps[0][0][1] = -2;
      conv_maps[0][1][0] = -9;   conv_maps[0][1][1] = -100;
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++) begin
            conv_maps[5][6+a][8+b]   = 32'sh7FFFFFFF;
            conv_maps[9][12+a][12+b] = 32'sh80000000;
         end
      compute_expected();
      start_pass();
      wait_done(lat);
      n_cmp++;
      if (lat !== c_LAT) begin n_bad++; $display("FAIL signed_latency got=%0d want=%0d", lat, c_LAT); end
`ifdef POOL2_AVG_EN
      want = -29;
`else
      want = -2;
`endif
      n_cmp++;
      if (pool_maps[0][0][0] !== want)
         begin n_bad++; $display("FAIL signed_window got=%0d want=%0d", pool_maps[0][0][0], want); end
      n_cmp++;
      if (pool_maps[5][3][4] !== 32'sh7FFFFFFF)
         begin n_bad++; $display("FAIL max_pos got=%h want=7fffffff", pool_maps[5][3][4]); end
      n_cmp++;
      if (pool_maps[9][6][6] !== 32'sh80000000)
         begin n_bad++; $display("FAIL max_neg got=%h want=80000000", pool_maps[9][6][6]); end
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL signed_maps bad_entries=%0d want=0", map_diff()); end
   endtask

   task automatic test_handshake;
      int lat;
      old_maps = pool_maps;
      fill_random();
      compute_expected();
      start_pass();
      while (cyc < 99) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      // Output 19 (f0,i2,j5) lands on edge 100; output 20 is still the old value.
      n_cmp++;
      if (pool_maps[0][2][5] !== exp_maps[0][2][5])
         begin n_bad++; $display("FAIL hs_out19 got=%0d want=%0d", pool_maps[0][2][5], exp_maps[0][2][5]); end
      n_cmp++;
      if (pool_maps[0][2][6] !== old_maps[0][2][6])
         begin n_bad++; $display("FAIL hs_out20_early got=%0d want=%0d", pool_maps[0][2][6], old_maps[0][2][6]); end
      wait_done(lat);
      n_cmp++;
      if (lat !== c_LAT) begin n_bad++; $display("FAIL hs_latency got=%0d want=%0d", lat, c_LAT); end
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL hs_maps bad_entries=%0d want=0", map_diff()); end
      start_pass();
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_clear got=%b want=0", done); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
      wait_done(lat);
      n_cmp++;
      if (lat !== c_LAT) begin n_bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, c_LAT); end
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL b2b_maps bad_entries=%0d want=0", map_diff()); end
   endtask

   task automatic test_midreset;
      int lat;
      fill_random();
      start_pass();
      while (cyc < 2999) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL mr_busy got=%b want=0", busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL mr_done got=%b want=0", done); end
      for (int f = 0; f < c_NM; f++)
         for (int i = 0; i < c_OD; i++)
            for (int j = 0; j < c_OD; j++) exp_maps[f][i][j] = '0;
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL mr_maps nonzero_entries=%0d want=0", map_diff()); end
      compute_expected();
      start_pass();
      wait_done(lat);
      n_cmp++;
      if (lat !== c_LAT) begin n_bad++; $display("FAIL mr_latency got=%0d want=%0d", lat, c_LAT); end
      n_cmp++;
      if (map_diff() !== 0) begin n_bad++; $display("FAIL mr_maps_pass bad_entries=%0d want=0", map_diff()); end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      for (int f = 0; f < c_NM; f++)
         for (int r = 0; r < c_ID; r++)
            for (int c = 0; c < c_ID; c++) conv_maps[f][r][c] = '0;
      test_reset();
      test_ramp();
      test_signed_extremes();
      test_handshake();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pool2.md
# pool2

Second pooling stage of the quickdraw CNN datapath. It consumes the 32 ReLU'd 14x14 feature maps produced by the conv2 stage and writes 32 pooled 7x7 maps for the flatten/dense stage. The block reads conv2's map array one element per cycle, selects the result of each non-overlapping 2x2 window (stride 2), and writes it. It uses the same start/done handshake as the convolution stages, so it can be sequenced directly after conv2's done.

## Interface
Parameters:
- NUM_MAPS, 32, number of feature maps (filters) to pool
- IN_DIM, 14, input map height and width (must be even)
- OUT_DIM, IN_DIM/2 = 7, output map height and width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge)
- conv_maps  input  signed 32 x [NUM_MAPS][IN_DIM][IN_DIM]  conv2 output maps; must hold stable from start until done
- start  input  1  begin a pooling pass; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until the DONE state exits
- done  output  1  set when the pass completes; held high until the next accepted start
- pool_maps  output  signed 32 x [NUM_MAPS][OUT_DIM][OUT_DIM]  pooled result maps

## Operation
- Counters:
  - f: 0..NUM_MAPS-1
  - i, j: 0..OUT_DIM-1 (output coordinates)
  - k: 0..3 (window element)
  - acc: signed 32-bit (34-bit when averaging)
- States and transitions:
  - IDLE: on start, clear f, i, j, k and done, set busy, go to READ. Otherwise stay.
  - READ: read element conv_maps[f][2i+k[1]][2j+k[0]] (row-major order: (0,0), (0,1), (1,0), (1,1)).
    - k==0: acc <= element.
    - k>0: acc <= max(acc, element), as a signed comparison.
    - Increment k. After k==3, go to WRITE with k reset to 0.
  - WRITE: pool_maps[f][i][j] <= acc. Advance j, then i, then f (j wraps at OUT_DIM-1 and carries into i; i wraps and carries into f).
    - If f, i and j are all at their last values, go to DONE.
    - Otherwise go to READ.
  - DONE: done <= 1, busy <= 0, go to IDLE.
- Every pass rewrites all pool_maps entries. Entries not yet written in the current pass keep their previous values.
- start outside IDLE is ignored, including start held high through DONE.
- A new start in IDLE while done=1 clears done on the accepting edge.
- Negative inputs compare correctly (signed). Equal values: either choice is identical.

## Timing
- Reset (reset==0 at a clk edge) from any state: state=IDLE, all counters=0, done=0, busy=0, every pool_maps entry=0. A pass in flight is abandoned.
- Each output takes 5 cycles: 4 READ + 1 WRITE.
- With start accepted at edge E0:
  - output n (n = f*49 + i*7 + j) is written at edge E0+5(n+1);
  - the final output is written at E0+7840;
  - done rises at E0+7841, when busy falls and state returns to IDLE.
- Earliest next accepted start is at the edge after done rises.
- Total start-to-done latency is NUM_MAPS*OUT_DIM^2*5 + 1 cycles.

## Configuration
- POOL2_AVG_EN defined: average pooling instead of max.
  - READ: k==0 loads the sign-extended element into a 34-bit acc; k>0 adds the element.
  - WRITE stores acc >>> 2 (arithmetic shift, rounds toward negative infinity), truncated to 32 bits.
  - Timing is identical.
- POOL2_AVG_EN undefined: signed max pooling as described in Operation.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 -> done=0, busy=0, all pool_maps=0, and start is not accepted while reset=0.
- Ramp: conv_maps[f][r][c]=f*1000+r*14+c, then start -> pool_maps[f][i][j]=f*1000+(2i+1)*14+2j+1. For example, [3][6][6]=3195. done rises exactly 7841 cycles after start.
- Signed max: window of map 0 at (0,0) = {-5, -2, -9, -100} -> pool_maps[0][0][0]=-2. Same test with POOL2_AVG_EN: (-116)>>>2 = -29.
- Handshake: pulse start again at cycle 100 of a pass -> ignored and the pass completes on schedule. start in IDLE after done -> done drops on the next edge and a second pass reproduces identical results.
- Mid-pass reset: assert reset=0 at cycle 3000 -> next cycle has state IDLE and all outputs 0. A following start completes a full pass with correct values.
- Overflow under POOL2_AVG_EN: window of four 32'h7FFFFFFF -> 34-bit sum, and the result is 32'h7FFFFFFF with no wrap.
